// File: rtl/mem_pkt_writer.sv
// -----------------------------------------------------------------------------
// mem_pkt_writer
//   Reads a destination pointer from a descriptor in memory, then streams one
//   packet (header word + payload words) from the rx interface into memory at
//   that destination. A status word {1, err, 14'b0, len} is written back just
//   after the descriptor. Payloads longer than MAX_WORDS are consumed but not
//   stored (err=1).
//
// Ports
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   start, desc_addr  : transfer request (sampled in IDLE) and descriptor addr
//   busy, done        : not-idle flag, one-cycle completion pulse
//   rx_data/valid/ready : incoming packet word stream (valid/ready handshake)
//   addr_in, data_in, wb_in : memory request (wb_in 0 = read, F = write)
//   data_out          : memory read data, one cycle after the read address
// -----------------------------------------------------------------------------
module mem_pkt_writer #(
    parameter int MEMORY_BUS_WIDTH = 32,   // only 32 is supported
    parameter int MAX_WORDS        = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MEMORY_BUS_WIDTH-1:0] desc_addr,
    output logic                        busy,
    output logic                        done,
    input  logic [MEMORY_BUS_WIDTH-1:0] rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [MEMORY_BUS_WIDTH-1:0] addr_in,
    output logic [MEMORY_BUS_WIDTH-1:0] data_in,
    output logic [3:0]                  wb_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_DESC_RD, S_DESC_WAIT, S_HDR, S_PAYLOAD, S_DROP, S_STATUS, S_DONE
    } state_t;

    state_t                      r_state;
    logic [MEMORY_BUS_WIDTH-1:0] r_desc;
    logic [MEMORY_BUS_WIDTH-1:0] r_dest;
    logic [15:0]                 r_len;
    logic [15:0]                 r_cnt;   // payload words already taken
    logic                        r_err;

    logic                        w_hs;
    logic [15:0]                 w_hdr_len;
    logic                        w_last;

    // Gating with reset keeps the reset cycle itself free of handshakes and
    // writes, so an aborted transfer leaves no trace in memory.
    assign rx_ready  = !reset && (r_state == S_HDR || r_state == S_PAYLOAD ||
                                  r_state == S_DROP);
    assign w_hs      = rx_valid && rx_ready;
    assign w_hdr_len = rx_data[15:0];
    assign w_last    = (r_cnt == r_len - 16'd1);

    assign busy = (r_state != S_IDLE);
    assign done = !reset && (r_state == S_DONE);

    // Memory request is combinational so a write lands in the handshake cycle.
    always_comb begin
        addr_in = '0;
        data_in = '0;
        wb_in   = 4'h0;
        if (!reset) begin
            case (r_state)
                S_DESC_RD: addr_in = r_desc;
                S_HDR: if (w_hs) begin
                    addr_in = r_dest;
                    data_in = rx_data;
                    wb_in   = 4'hF;
                end
                S_PAYLOAD: if (w_hs) begin
                    // k-th word (k = r_cnt+1) goes to dest + 4k, wrapping mod 2^32
                    addr_in = r_dest + (({16'b0, r_cnt} + 32'd1) << 2);
                    data_in = rx_data;
                    wb_in   = 4'hF;
                end
                S_STATUS: begin
                    addr_in = r_desc + 32'd4;
                    data_in = {1'b1, r_err, 14'b0, r_len};
                    wb_in   = 4'hF;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_desc  <= '0;
            r_dest  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_desc  <= desc_addr;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_DESC_RD;
                end
                S_DESC_RD:   r_state <= S_DESC_WAIT;
                S_DESC_WAIT: begin
                    r_dest  <= data_out & 32'hFFFF_FFFC;
                    r_state <= S_HDR;
                end
                S_HDR: if (w_hs) begin
                    r_len <= w_hdr_len;
                    r_cnt <= '0;
                    if (w_hdr_len == 16'd0)
                        r_state <= S_STATUS;
                    else if ({16'b0, w_hdr_len} > 32'(MAX_WORDS)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DROP;
                    end else
                        r_state <= S_PAYLOAD;
                end
                S_PAYLOAD, S_DROP: if (w_hs) begin
                    if (w_last) r_state <= S_STATUS;
                    else        r_cnt   <= r_cnt + 16'd1;
                end
                S_STATUS: r_state <= S_DONE;
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule
